// File: rtl/comp_nibble_seq.sv
// Wide unsigned magnitude compare: one 4-bit comp1 stepped MSB nibble first, registered less/greater/eq result.
// Latency: NIBBLES edges accept->res_valid; with COMP_NIBBLE_SEQ_EARLY_EXIT_EN defined, k+1 (k = first mismatching nibble from the top).
// Backpressure: result held in DONE while res_ready=0; start_ready only in IDLE, requests elsewhere ignored (no queuing).

module comp1 (
    output logic       less,
    output logic       greater,
    output logic       eq,
    input  logic [3:0] a,
    input  logic [3:0] b
);
    assign less    = (a < b);
    assign greater = (a > b);
    assign eq      = (a == b);
endmodule

module comp_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [4*NIBBLES-1:0] a_in,
    input  logic [4*NIBBLES-1:0] b_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 less,
    output logic                 greater,
    output logic                 eq,
    output logic                 busy
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_n;
    logic [W-1:0]    a_q, a_n;
    logic [W-1:0]    b_q, b_n;
    logic [IDXW-1:0] idx_q, idx_n;
    logic            less_q, less_n;
    logic            greater_q, greater_n;
    logic            eq_q, eq_n;
    logic            mism_q, mism_n;

    logic [3:0]      a_nib, b_nib;
    logic            c_less, c_greater, c_eq;
    logic            new_mism;
    logic            early;

    assign a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = b_q[{idx_q, 2'b00} +: 4];

    comp1 u_comp1 (c_less, c_greater, c_eq, a_nib, b_nib);

    // Only the first unequal nibble from the top decides the ordering.
    assign new_mism = !c_eq && !mism_q;

`ifdef COMP_NIBBLE_SEQ_EARLY_EXIT_EN
    assign early = new_mism;
`else
    assign early = 1'b0;
`endif

    always_comb begin
        state_n   = state_q;
        a_n       = a_q;
        b_n       = b_q;
        idx_n     = idx_q;
        less_n    = less_q;
        greater_n = greater_q;
        eq_n      = eq_q;
        mism_n    = mism_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_n       = a_in;
                    b_n       = b_in;
                    idx_n     = IDXW'(NIBBLES - 1);
                    less_n    = 1'b0;
                    greater_n = 1'b0;
                    eq_n      = 1'b0;
                    mism_n    = 1'b0;
                    state_n   = CMP;
                end
            end
            CMP: begin
                if (new_mism) begin
                    less_n    = c_less;
                    greater_n = c_greater;
                    mism_n    = 1'b1;
                end
                if (idx_q == '0 || early) begin
                    eq_n    = !(mism_q || new_mism);
                    state_n = DONE;
                end else begin
                    idx_n = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (res_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            less_q    <= 1'b0;
            greater_q <= 1'b0;
            eq_q      <= 1'b0;
            mism_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            a_q       <= a_n;
            b_q       <= b_n;
            idx_q     <= idx_n;
            less_q    <= less_n;
            greater_q <= greater_n;
            eq_q      <= eq_n;
            mism_q    <= mism_n;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign less        = less_q;
    assign greater     = greater_q;
    assign eq          = eq_q;
endmodule

// File: tb/tb_comp_nibble_seq.sv
// Directed-vector bench for comp_nibble_seq (NIBBLES=4); expected latency follows COMP_NIBBLE_SEQ_EARLY_EXIT_EN.
module tb_comp_nibble_seq;
    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        res_valid;
    logic        res_ready;
    logic        less;
    logic        greater;
    logic        eq;
    logic        busy;

    int vectors = 0;
    int fails   = 0;

`ifdef COMP_NIBBLE_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    comp_nibble_seq #(.NIBBLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .less        (less),
        .greater     (greater),
        .eq          (eq),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] a, input logic [15:0] b);
        a_in        = a;
        b_in        = b;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        a_in        = 16'hDEAD;
        b_in        = 16'hBEEF;
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        while (!res_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] lge, input int exp_lat);
        int lat;
        accept(a, b);
        chk({tag, "_busy"}, {busy, start_ready}, 2'b10);
        wait_res(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_lge"}, {less, greater, eq}, lge);
    endtask

    initial begin
        int lat;
        rst         = 1'b1;
        start_valid = 1'b0;
        res_ready   = 1'b1;
        a_in        = '0;
        b_in        = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_outs", {start_ready, res_valid, busy, less, greater, eq}, 6'b100000);

        run_op("equal", 16'h9D31, 16'h9D31, 3'b001, 4);
        tick();
        chk("equal_back_idle", {start_ready, res_valid, busy}, 3'b100);
        chk("equal_held", {less, greater, eq}, 3'b001);

        run_op("lsb", 16'h1234, 16'h1235, 3'b100, 4);
        tick();

        run_op("msb", 16'h5000, 16'h1FFF, 3'b010, EARLY ? 1 : 4);
        tick();

        res_ready = 1'b0;
        run_op("bp", 16'hB0F0, 16'hF000, 3'b100, EARLY ? 1 : 4);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a_in        = 16'hFFFF;
                b_in        = 16'h0000;
                start_valid = 1'b1;
            end
            tick();
            start_valid = 1'b0;
            chk("bp_hold", {res_valid, start_ready, less, greater, eq}, 5'b10100);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_release", {start_ready, res_valid, busy}, 3'b100);
        chk("bp_no_accept", {less, greater, eq}, 3'b100);

        res_ready = 1'b0;
        accept(16'hFFFF, 16'h0000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid", {start_ready, res_valid, busy, less, greater, eq}, 6'b100000);
        tick();
        chk("rst_stays_idle", {start_ready, res_valid, busy}, 3'b100);

        res_ready = 1'b1;
        run_op("post_rst", 16'h0001, 16'h0002, 3'b100, 4);
        tick();
        chk("final_idle", {start_ready, res_valid}, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
